// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: one 4-bit compare slice per clock over WIDTH-bit operands.
// Define SMC_EARLY_TERM_EN for an MSB-first scan that stops at the first unequal nibble.
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt,
    output logic             a_lt,
    output logic             a_eq
);

    localparam int NIBBLES = (WIDTH + 3) / 4;
    localparam int NW      = NIBBLES * 4;
    localparam int CW      = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   a_q, a_d, b_q, b_d;
    logic [NW-1:0]   a_ext, b_ext;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      casc_q, casc_d;
    logic [2:0]      res_q, res_d;
    logic [3:0]      a_nib, b_nib;
    logic [2:0]      step;
    logic            finish;

    always_comb begin
        a_ext              = '0;
        b_ext              = '0;
        a_ext[WIDTH-1:0]   = a;
        b_ext[WIDTH-1:0]   = b;

`ifdef SMC_EARLY_TERM_EN
        a_nib = a_q[NW-1 -: 4];
        b_nib = b_q[NW-1 -: 4];
`else
        a_nib = a_q[3:0];
        b_nib = b_q[3:0];
`endif

        // One slice: an unequal nibble overrides the cascade, an equal one passes it on.
        if (a_nib > b_nib) begin
            step = 3'b100;
        end else if (a_nib < b_nib) begin
            step = 3'b010;
        end else begin
            step = casc_q;
        end

`ifdef SMC_EARLY_TERM_EN
        finish = (cnt_q == LAST_IDX) || (a_nib != b_nib);
`else
        finish = (cnt_q == LAST_IDX);
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        casc_d  = casc_q;
        res_d   = res_q;

        case (state_q)
            S_RUN: begin
                cnt_d  = cnt_q + 1'b1;
                casc_d = step;
`ifdef SMC_EARLY_TERM_EN
                a_d    = a_q << 4;
                b_d    = b_q << 4;
`else
                a_d    = a_q >> 4;
                b_d    = b_q >> 4;
`endif
                if (finish) begin
                    state_d = S_DONE;
                    res_d   = step;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start is honoured in IDLE and DONE alike; it restarts the cascade and clears the result.
        if (start && (state_q != S_RUN)) begin
            state_d = S_RUN;
            a_d     = a_ext;
            b_d     = b_ext;
            cnt_d   = '0;
            casc_d  = 3'b001;
            res_d   = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            casc_q  <= 3'b001;
            res_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign {a_gt, a_lt, a_eq} = res_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench for serial_mag_compare_ctrl at WIDTH=16 and WIDTH=10.
module tb_serial_mag_compare_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start10;
    logic [15:0] a16, b16;
    logic [9:0]  a10, b10;
    logic        busy16, done16, gt16, lt16, eq16;
    logic        busy10, done10, gt10, lt10, eq10;

    always #5 clk = ~clk;

    serial_mag_compare_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .a_gt(gt16), .a_lt(lt16), .a_eq(eq16)
    );

    serial_mag_compare_ctrl #(.WIDTH(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .a(a10), .b(b10),
        .busy(busy10), .done(done10), .a_gt(gt10), .a_lt(lt10), .a_eq(eq10)
    );

    typedef struct {
        logic [2:0] flags;
        int         done_cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         inst = 0;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] held = 3'b000;
    int         run_lo = -1;
    int         run_hi = -2;
    int         next_ok = 0;
    bit         mon_en = 1'b0;

    logic       m_busy, m_done;
    logic [2:0] m_flags;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_busy  = (inst == 0) ? busy16 : busy10;
        m_done  = (inst == 0) ? done16 : done10;
        m_flags = (inst == 0) ? {gt16, lt16, eq16} : {gt10, lt10, eq10};
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nibs();
        return (inst == 0) ? 4 : 3;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [15:0] x, input logic [15:0] y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y, input int n);
`ifdef SMC_EARLY_TERM_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (((x >> (4 * i)) & 16'hF) != ((y >> (4 * i)) & 16'hF)) return n - i;
        end
`endif
        return n;
    endfunction

    // Present one cycle of stimulus; model acceptance from the spec's busy window.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input bit s);
        logic [15:0] am, bm;
        int          e, lat;
        am = (inst == 0) ? av : (av & 16'h03FF);
        bm = (inst == 0) ? bv : (bv & 16'h03FF);
        a16 = av;
        b16 = bv;
        a10 = av[9:0];
        b10 = bv[9:0];
        start16 = s && (inst == 0);
        start10 = s && (inst == 1);
        @(posedge clk);
        #1;
        e = cyc;
        if (s && (e >= next_ok)) begin
            lat = ref_lat(am, bm, nibs());
            q.push_back('{ref_flags(am, bm), e + lat});
            held    = 3'b000;
            run_lo  = e;
            run_hi  = e + lat - 1;
            next_ok = e + lat + 1;
        end
        start16 = 1'b0;
        start10 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        q.delete();
        held    = 3'b000;
        run_lo  = -1;
        run_hi  = -2;
        next_ok = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1, expected no pending compare (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("result", int'(m_flags), int'(e.flags));
                    held = e.flags;
                end
                check("onehot", int'($onehot(m_flags)), 1);
            end
            if ((q.size() != 0) && (cyc > q[0].done_cyc)) begin
                checks++;
                errors++;
                $display("FAIL missing_done: got no done, expected done at cycle %0d (now %0d)", q[0].done_cyc, cyc);
                void'(q.pop_front());
            end
            check("busy", int'(m_busy), int'((cyc >= run_lo) && (cyc <= run_hi)));
            check("flags_held", int'(m_flags), int'(held));
        end
    end

    initial begin
        logic [15:0] ra, rb;
        int          wait_cnt;
        rst = 1'b1;
        start16 = 1'b0;
        start10 = 1'b0;
        a16 = '0; b16 = '0; a10 = '0; b10 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        next_ok = cyc + 1;
        check("rst_busy16", int'(busy16), 0);
        check("rst_done16", int'(done16), 0);
        check("rst_flags16", int'({gt16, lt16, eq16}), 0);
        check("rst_busy10", int'(busy10), 0);
        check("rst_flags10", int'({gt10, lt10, eq10}), 0);
        mon_en = 1'b1;

        issue(16'h1234, 16'h1234, 1'b1); idle(6);
        issue(16'h8000, 16'h7FFF, 1'b1); idle(6);
        // Second start lands exactly in the DONE cycle of the first.
        issue(16'h0001, 16'h0002, 1'b1); idle(4);
        issue(16'h0005, 16'h0003, 1'b1); idle(6);
        // Start during RUN must be dropped.
        issue(16'h0010, 16'h0020, 1'b1); idle(1);
        issue(16'hFFFF, 16'h0000, 1'b1); idle(6);
        issue(16'hFFFF, 16'hFFFF, 1'b1); idle(6);
        issue(16'h0000, 16'hFFFF, 1'b1); idle(6);
        // Reset in the middle of a compare aborts it.
        issue(16'hABCD, 16'h1234, 1'b1); idle(2);
        do_reset();
        check("midrst_busy", int'(busy16), 0);
        check("midrst_done", int'(done16), 0);
        check("midrst_flags", int'({gt16, lt16, eq16}), 0);
        idle(6);
        issue(16'h4321, 16'h4322, 1'b1); idle(6);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            issue(ra, rb, 1'b1);
            idle($urandom_range(0, 5));
        end
        idle(8);

        inst = 1;
        held = 3'b000;
        idle(2);
        issue(16'h03FF, 16'h03FF, 1'b1); idle(5);
        issue(16'h0200, 16'h01FF, 1'b1); idle(3);
        issue(16'h0001, 16'h0002, 1'b1); idle(5);
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            issue(ra, rb, 1'b1);
            idle($urandom_range(0, 4));
        end

        wait_cnt = 0;
        while ((q.size() != 0) && (wait_cnt < 50)) begin
            idle(1);
            wait_cnt++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
